// File: rtl/tdm_pcm_rx.sv
// Serial TDM PCM receiver: oversamples ser_clk/ser_in/ser_fs, deserializes MSB-first
// channel bytes and queues {ch, byte} into a small FIFO. Define TDM_RX_FS_CHECK_EN for o_frame_err.
module tdm_pcm_rx #(
    parameter int NUM_CH      = 32,
    parameter int CH_BITS     = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = $clog2(NUM_CH),
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               ser_in,
    input  logic               ser_clk,
    input  logic               ser_fs,
    output logic [CH_BITS-1:0] o_data,
    output logic [CH_W-1:0]    o_ch,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [LVL_W-1:0]   o_level,
    output logic               o_overflow,
    input  logic               i_ovf_clr
`ifdef TDM_RX_FS_CHECK_EN
    ,
    output logic               o_frame_err
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BC_W  = $clog2(CH_BITS + 1);

    typedef struct packed {
        logic [CH_W-1:0]    ch;
        logic [CH_BITS-1:0] data;
    } entry_t;

    typedef enum logic {IDLE, SHIFT} state_t;

    // ---------------- input synchronizers / bit-edge detect ----------------
    logic [SYNC_STAGES-1:0] sclk_sync, sin_sync, sfs_sync;
    logic                   sclk_prev;
    logic                   bit_edge, s_bit, s_fs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            sin_sync  <= '0;
            sfs_sync  <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ser_clk};
            sin_sync  <= {sin_sync[SYNC_STAGES-2:0], ser_in};
            sfs_sync  <= {sfs_sync[SYNC_STAGES-2:0], ser_fs};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign bit_edge = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign s_bit    = sin_sync[SYNC_STAGES-1];
    assign s_fs     = sfs_sync[SYNC_STAGES-1];

    // ---------------- deserializer FSM ----------------
    state_t             state, state_n;
    logic [CH_BITS-1:0] sr, sr_n, sr_shift;
    logic [BC_W-1:0]    bitcnt, bitcnt_n;
    logic [CH_W-1:0]    ch, ch_n;
    logic               push;
`ifdef TDM_RX_FS_CHECK_EN
    logic               wrap_pend, wrap_pend_n, ferr_n;
`endif

    assign sr_shift = {sr[CH_BITS-2:0], s_bit};

    always_comb begin
        state_n  = state;
        sr_n     = sr;
        bitcnt_n = bitcnt;
        ch_n     = ch;
        push     = 1'b0;
`ifdef TDM_RX_FS_CHECK_EN
        wrap_pend_n = wrap_pend;
        ferr_n      = 1'b0;
`endif
        if (!enable) begin
            state_n  = IDLE;
            bitcnt_n = '0;
            ch_n     = '0;
`ifdef TDM_RX_FS_CHECK_EN
            wrap_pend_n = 1'b0;
`endif
        end else if (bit_edge) begin
            case (state)
                IDLE: begin
                    if (s_fs) begin
                        state_n  = SHIFT;
                        sr_n     = CH_BITS'(s_bit);
                        bitcnt_n = BC_W'(1);
                        ch_n     = '0;
                    end
                end
                SHIFT: begin
                    if (s_fs) begin
                        // resync: partial byte dropped, this bit is ch0's MSB
                        sr_n     = CH_BITS'(s_bit);
                        bitcnt_n = BC_W'(1);
                        ch_n     = '0;
`ifdef TDM_RX_FS_CHECK_EN
                        ferr_n      = !(bitcnt == '0 && ch == '0);
                        wrap_pend_n = 1'b0;
`endif
                    end else begin
                        sr_n = sr_shift;
`ifdef TDM_RX_FS_CHECK_EN
                        ferr_n      = wrap_pend;
                        wrap_pend_n = 1'b0;
`endif
                        if (bitcnt == BC_W'(CH_BITS - 1)) begin
                            push     = 1'b1;
                            bitcnt_n = '0;
                            ch_n     = ch + 1'b1;
`ifdef TDM_RX_FS_CHECK_EN
                            wrap_pend_n = (ch == CH_W'(NUM_CH - 1));
`endif
                        end else begin
                            bitcnt_n = bitcnt + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sr     <= '0;
            bitcnt <= '0;
            ch     <= '0;
        end else begin
            state  <= state_n;
            sr     <= sr_n;
            bitcnt <= bitcnt_n;
            ch     <= ch_n;
        end
    end

`ifdef TDM_RX_FS_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_pend   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            wrap_pend   <= wrap_pend_n;
            o_frame_err <= ferr_n;
        end
    end
`endif

    // ---------------- output FIFO with registered head ----------------
    entry_t [FIFO_DEPTH-1:0] mem;
    logic [PTR_W-1:0]        rd_ptr, wr_ptr, rd_nx;
    logic [LVL_W-1:0]        count;
    logic                    pop, full, wr_en, ovf_set;
    entry_t                  head;

    assign pop     = o_valid & i_ready;
    assign full    = (count == LVL_W'(FIFO_DEPTH));
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;
    assign rd_nx   = rd_ptr + PTR_W'(pop);
    assign o_level = count;
    assign o_data  = head.data;
    assign o_ch    = head.ch;

    // Head registers only look at entries already stored, so a fresh push shows up one clk later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (!enable) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                o_valid <= 1'b0;
            end else begin
                if (wr_en) begin
                    mem[wr_ptr] <= '{ch: ch, data: sr_shift};
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                rd_ptr  <= rd_nx;
                count   <= count + LVL_W'(wr_en) - LVL_W'(pop);
                o_valid <= (count != LVL_W'(pop));
                head    <= mem[rd_nx];
            end
            if (ovf_set)
                o_overflow <= 1'b1;
            else if (i_ovf_clr)
                o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdm_pcm_rx.sv
// Randomized bench for tdm_pcm_rx: builds serial bit streams, predicts the byte stream
// from the framing rules, and compares the handshaked outputs.
module tb_tdm_pcm_rx;
    localparam int NUM_CH = 32, CH_BITS = 8, FIFO_DEPTH = 4, SYNC_STAGES = 2;
    localparam int CH_W = $clog2(NUM_CH), LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = CH_W + CH_BITS;

    logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
    logic ser_in = 1'b0, ser_clk = 1'b0, ser_fs = 1'b0;
    logic i_ready = 1'b0, i_ovf_clr = 1'b0;
    logic [CH_BITS-1:0] o_data;
    logic [CH_W-1:0]    o_ch;
    logic               o_valid, o_overflow;
    logic [LVL_W-1:0]   o_level;
`ifdef TDM_RX_FS_CHECK_EN
    logic               o_frame_err;
`endif

    tdm_pcm_rx #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .FIFO_DEPTH(FIFO_DEPTH),
                 .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .ser_in(ser_in), .ser_clk(ser_clk), .ser_fs(ser_fs),
        .o_data(o_data), .o_ch(o_ch), .o_valid(o_valid), .i_ready(i_ready),
        .o_level(o_level), .o_overflow(o_overflow), .i_ovf_clr(i_ovf_clr)
`ifdef TDM_RX_FS_CHECK_EN
        , .o_frame_err(o_frame_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int half_ns = 40;
    int ferr_cnt = 0;
    bit tx_bit[$];
    bit tx_fs[$];
    logic [ENT_W-1:0] exp_q[$];
    logic [ENT_W-1:0] got_q[$];

    always @(negedge clk)
        if (o_valid === 1'b1 && i_ready) got_q.push_back({o_ch, o_data});
`ifdef TDM_RX_FS_CHECK_EN
    always @(negedge clk)
        if (o_frame_err === 1'b1) ferr_cnt++;
`endif

    task automatic add_byte(input logic [CH_BITS-1:0] b, input bit fs0);
        for (int k = CH_BITS - 1; k >= 0; k--) begin
            tx_bit.push_back(b[k]);
            tx_fs.push_back(fs0 && (k == CH_BITS - 1));
        end
    endtask

    task automatic send_bit(input bit b, input bit f);
        ser_in = b; ser_fs = f;
        #(half_ns); ser_clk = 1'b1;
        #(half_ns); ser_clk = 1'b0;
    endtask

    task automatic play(input int from, input int to);
        for (int i = from; i < to; i++) send_bit(tx_bit[i], tx_fs[i]);
    endtask

    // Expected bytes: every full CH_BITS group after the latest fs; channel = group index mod NUM_CH.
    function automatic void ref_decode();
        int start, k;
        logic [CH_BITS-1:0] b;
        start = -1;
        exp_q.delete();
        for (int i = 0; i < tx_bit.size(); i++) begin
            if (tx_fs[i]) start = i;
            if (start >= 0 && ((i - start + 1) % CH_BITS) == 0) begin
                k = (i - start + 1) / CH_BITS - 1;
                for (int j = 0; j < CH_BITS; j++) b[CH_BITS-1-j] = tx_bit[i-CH_BITS+1+j];
                exp_q.push_back({CH_W'(k % NUM_CH), b});
            end
        end
    endfunction

    task automatic restart(input logic rdy);
        @(posedge clk); #1 enable = 1'b0; i_ready = rdy;
        @(posedge clk); #1 enable = 1'b1;
        ser_in = 1'b0; ser_fs = 1'b0;
        tx_bit.delete(); tx_fs.delete(); got_q.delete();
        ferr_cnt = 0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk); #1;
            if (o_valid === 1'b0 && o_level === '0) done = 1;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s drain timeout level=%0d want 0", name, o_level);
        end
    endtask

    task automatic test_reset();
        #12;
        checks += 6;
        if (o_data !== '0)    begin errors++; $display("FAIL reset_o_data got %h want 0", o_data); end
        if (o_ch !== '0)      begin errors++; $display("FAIL reset_o_ch got %0d want 0", o_ch); end
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
        if (o_level !== '0)   begin errors++; $display("FAIL reset_o_level got %0d want 0", o_level); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_o_overflow got %b want 0", o_overflow); end
`ifdef TDM_RX_FS_CHECK_EN
        if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_o_frame_err got %b want 0", o_frame_err); end
`else
        if (dut.state !== dut.IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
`endif
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_aligned_frame();
        half_ns = 244;
        restart(1'b1);
        for (int n = 0; n < NUM_CH; n++) add_byte(8'hA0 + n[7:0], n == 0);
        ref_decode();
        play(0, tx_bit.size());
        wait_drain("aligned");
        checks++;
        if (got_q.size() != NUM_CH) begin errors++; $display("FAIL aligned_count got %0d want %0d", got_q.size(), NUM_CH); end
        for (int i = 0; i < NUM_CH && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {CH_W'(i), 8'hA0 + i[7:0]}) begin
                errors++; $display("FAIL aligned_entry[%0d] got %h want %h", i, got_q[i], {CH_W'(i), 8'hA0 + i[7:0]});
            end
        end
        checks++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL aligned_overflow got %b want 0", o_overflow); end
`ifdef TDM_RX_FS_CHECK_EN
        checks++;
        if (ferr_cnt != 0) begin errors++; $display("FAIL aligned_frame_err got %0d want 0", ferr_cnt); end
`endif
        half_ns = 40;
    endtask

    task automatic test_backpressure();
        restart(1'b0);
        for (int n = 0; n < 10; n++) add_byte(8'($urandom), n == 0);
        ref_decode();
        play(0, 6 * CH_BITS);
        repeat (8) @(posedge clk);
        #1;
        checks += 4;
        if (o_level !== LVL_W'(FIFO_DEPTH)) begin errors++; $display("FAIL bp_level got %0d want %0d", o_level, FIFO_DEPTH); end
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", o_overflow); end
        if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", o_valid); end
        if ({o_ch, o_data} !== exp_q[0]) begin errors++; $display("FAIL bp_head got %h want %h", {o_ch, o_data}, exp_q[0]); end
        exp_q.delete(5);
        exp_q.delete(4);
        @(posedge clk); #1 i_ready = 1'b1;
        play(6 * CH_BITS, tx_bit.size());
        wait_drain("backpressure");
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_entry[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky got %b want 1", o_overflow); end
        @(posedge clk); #1 i_ovf_clr = 1'b1;
        @(posedge clk); #1 i_ovf_clr = 1'b0;
        checks++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_clr got %b want 0", o_overflow); end
    endtask

    task automatic test_early_fs();
        restart(1'b1);
        for (int n = 0; n < 5; n++) add_byte(8'($urandom), n == 0);
        for (int k = 0; k < 3; k++) begin tx_bit.push_back(1'($urandom)); tx_fs.push_back(1'b0); end
        for (int n = 0; n < 4; n++) add_byte(8'($urandom), n == 0);
        ref_decode();
        play(0, tx_bit.size());
        wait_drain("early_fs");
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL early_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL early_entry[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
`ifdef TDM_RX_FS_CHECK_EN
        checks++;
        if (ferr_cnt != 1) begin errors++; $display("FAIL early_frame_err got %0d want 1", ferr_cnt); end
`endif
    endtask

    task automatic test_missing_fs();
        restart(1'b1);
        for (int n = 0; n < NUM_CH + 4; n++) add_byte(8'($urandom), n == 0);
        ref_decode();
        play(0, tx_bit.size());
        wait_drain("missing_fs");
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL missing_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL missing_entry[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
`ifdef TDM_RX_FS_CHECK_EN
        checks++;
        if (ferr_cnt != 1) begin errors++; $display("FAIL missing_frame_err got %0d want 1", ferr_cnt); end
`endif
    endtask

    task automatic test_enable();
        restart(1'b0);
        add_byte(8'($urandom), 1'b1);
        add_byte(8'($urandom), 1'b0);
        play(0, tx_bit.size());
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (o_level !== LVL_W'(2)) begin errors++; $display("FAIL en_level_pre got %0d want 2", o_level); end
        enable = 1'b0;
        @(posedge clk); #1;
        checks += 2;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL en_valid_off got %b want 0", o_valid); end
        if (o_level !== '0) begin errors++; $display("FAIL en_level_off got %0d want 0", o_level); end
        @(posedge clk); #1 enable = 1'b1; i_ready = 1'b1;
        tx_bit.delete(); tx_fs.delete(); got_q.delete();
        add_byte(8'($urandom), 1'b0);
        add_byte(8'($urandom), 1'b0);
        play(0, tx_bit.size());
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL en_no_fs_output got %0d want 0", got_q.size()); end
        for (int n = 0; n < 3; n++) add_byte(8'($urandom), n == 0);
        ref_decode();
        play(2 * CH_BITS, tx_bit.size());
        wait_drain("enable");
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL en_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL en_entry[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full_push_pop();
        int last;
        restart(1'b0);
        for (int n = 0; n < 6; n++) add_byte(8'($urandom), n == 0);
        ref_decode();
        last = 5 * CH_BITS - 1;
        play(0, last);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (o_level !== LVL_W'(FIFO_DEPTH)) begin errors++; $display("FAIL fpp_level_pre got %0d want %0d", o_level, FIFO_DEPTH); end
        ser_in = tx_bit[last]; ser_fs = 1'b0;
        #(half_ns); ser_clk = 1'b1;
        // push lands on the third clk after the rise; pop on that same clk
        repeat (2) @(posedge clk);
        #1 i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
        checks += 2;
        if (o_level !== LVL_W'(FIFO_DEPTH)) begin errors++; $display("FAIL fpp_level got %0d want %0d", o_level, FIFO_DEPTH); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got %b want 0", o_overflow); end
        #20 ser_clk = 1'b0;
        @(posedge clk); #1 i_ready = 1'b1;
        play(last + 1, tx_bit.size());
        wait_drain("full_push_pop");
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fpp_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fpp_entry[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_byte();
        restart(1'b0);
        for (int n = 0; n < 6; n++) add_byte(8'($urandom) | 8'h01, n == 0);
        play(0, 5 * CH_BITS + 3);
        #1 reset = 1'b0;
        #1;
        checks += 5;
        if (o_data !== '0)    begin errors++; $display("FAIL rst_mid_o_data got %h want 0", o_data); end
        if (o_ch !== '0)      begin errors++; $display("FAIL rst_mid_o_ch got %0d want 0", o_ch); end
        if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_o_valid got %b want 0", o_valid); end
        if (o_level !== '0)   begin errors++; $display("FAIL rst_mid_o_level got %0d want 0", o_level); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_o_overflow got %b want 0", o_overflow); end
        #20 reset = 1'b1;
        @(posedge clk); #1 i_ready = 1'b1;
        tx_bit.delete(); tx_fs.delete(); got_q.delete();
        for (int k = 0; k < 5; k++) begin tx_bit.push_back(1'($urandom)); tx_fs.push_back(1'b0); end
        for (int n = 0; n < 3; n++) add_byte(8'($urandom), n == 0);
        ref_decode();
        play(0, tx_bit.size());
        wait_drain("reset_mid_byte");
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_entry[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_aligned_frame();
        test_backpressure();
        test_early_fs();
        test_missing_fs();
        test_enable();
        test_full_push_pop();
        test_reset_mid_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
